// File: rtl/core_pkg.sv
// Shared constants for the 3-stage core: datapath width, reset/bubble values
// and the writeback-select encoding.
package core_pkg;
    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam int          CNT_W    = 16;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for debug event statistics; sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;

    // Count qualifying cycles, holding at the maximum instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
endmodule

// File: rtl/fetch_decode_pipe.sv
// Fetch PC, fetch->decode/execute and execute->writeback pipeline registers
// with operand forwarding muxes and stall/flush debug counters.
module fetch_decode_pipe
    import core_pkg::*;
#(
    parameter int          XLEN     = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = core_pkg::NOP_INST,
    parameter int          CNT_W    = core_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_f,
    input  logic             stall_d,
    input  logic             flush_d,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_target,
    input  logic [31:0]      imem_rdata,
    output logic [XLEN-1:0]  pc_f,
    output logic [31:0]      inst_d,
    output logic [XLEN-1:0]  pc_d,
    output logic             valid_d,
    input  logic [XLEN-1:0]  rf_rdata1,
    input  logic [XLEN-1:0]  rf_rdata2,
    input  logic             forward_ae,
    input  logic             forward_be,
    output logic [XLEN-1:0]  op_a,
    output logic [XLEN-1:0]  op_b,
    input  logic [XLEN-1:0]  result_e,
    input  logic [4:0]       waddr_e,
    input  logic             reg_wr_e,
    input  logic [1:0]       wb_sel_e,
    output logic [XLEN-1:0]  wb_data,
    output logic [4:0]       wb_waddr,
    output logic             wb_reg_wr,
    output logic [1:0]       wb_sel_m,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

    logic [XLEN-1:0] pc_f_r;
    logic [31:0]     inst_d_r;
    logic [XLEN-1:0] pc_d_r;
    logic            valid_d_r;
    logic [XLEN-1:0] wb_data_r;
    logic [4:0]      wb_waddr_r;
    logic            wb_reg_wr_r;
    logic [1:0]      wb_sel_m_r;

    // Fetch PC: a taken branch beats a fetch stall since that slot is flushed anyway
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_r <= RESET_PC;
        end else if (br_taken) begin
            pc_f_r <= br_target;
        end else if (stall_f) begin
            pc_f_r <= pc_f_r;
        end else begin
            pc_f_r <= pc_f_r + PC_STEP;
        end
    end

    // Decode/execute register: flush inserts a bubble even while stalled
    always_ff @(posedge clk) begin
        if (rst || flush_d) begin
            inst_d_r  <= NOP_INST;
            pc_d_r    <= {XLEN{1'b0}};
            valid_d_r <= 1'b0;
        end else if (stall_d) begin
            inst_d_r  <= inst_d_r;
            pc_d_r    <= pc_d_r;
            valid_d_r <= valid_d_r;
        end else begin
            inst_d_r  <= imem_rdata;
            pc_d_r    <= pc_f_r;
            valid_d_r <= 1'b1;
        end
    end

    // Writeback register: bubbles and x0 targets never raise a write/forward source
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_data_r   <= {XLEN{1'b0}};
            wb_waddr_r  <= 5'd0;
            wb_reg_wr_r <= 1'b0;
            wb_sel_m_r  <= WB_ALU;
        end else begin
            wb_data_r   <= result_e;
            wb_waddr_r  <= waddr_e;
            wb_reg_wr_r <= reg_wr_e & valid_d_r & (waddr_e != 5'd0);
            wb_sel_m_r  <= wb_sel_e;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_d),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_d),
        .count (flush_cnt)
    );

    assign pc_f      = pc_f_r;
    assign inst_d    = inst_d_r;
    assign pc_d      = pc_d_r;
    assign valid_d   = valid_d_r;
    assign wb_data   = wb_data_r;
    assign wb_waddr  = wb_waddr_r;
    assign wb_reg_wr = wb_reg_wr_r;
    assign wb_sel_m  = wb_sel_m_r;

    assign op_a = forward_ae ? wb_data_r : rf_rdata1;
    assign op_b = forward_be ? wb_data_r : rf_rdata2;
endmodule
